bcd_conv_sched: RTL and testbench

- Sequences a single shared iterative `division` unit to convert a binary word into packed BCD digits.
- Replaces the ten-stage cascaded divider chain with one time-multiplexed divider.
- Each pass divides the working value by 10, stores the remainder as the next digit, and feeds the quotient back in.
- Sits between the result producer (ALU/IO compare logic) and the seven-segment/display path.

---
 rtl/bcd_conv_sched.sv | 135 +++++++++++++
 tb/tb_bcd_conv_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Binary-to-BCD converter built around one shared iterative divider.
// Each pass divides the working value by 10; the remainder becomes the next digit.
module bcd_conv_sched #(
    parameter int WIDTH   = 32,
    parameter int DIGITS  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [WIDTH-1:0]             req_value,
    output logic                         req_ready,
    output logic                         div_start,
    output logic [WIDTH-1:0]             div_a,
    output logic [WIDTH-1:0]             div_b,
    input  logic                         div_busy,
    input  logic                         div_done,
    input  logic                         div_valid,
    input  logic [WIDTH-1:0]             div_val,
    input  logic [WIDTH-1:0]             div_rem,
    output logic [4*DIGITS-1:0]          bcd_o,
    output logic [$clog2(DIGITS+1)-1:0]  ndigits_o,
    output logic                         res_valid,
    output logic                         res_err,
    output logic                         busy
);
    localparam int NW = $clog2(DIGITS+1);
    localparam int TW = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUBLISH} state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_work;
    logic [4*DIGITS-1:0] r_digits, w_digits_wr;
    logic [NW-1:0]       r_idx, w_ndig_nxt;
    logic                r_err, w_err_nxt;
    logic [TW-1:0]       r_timer, w_timer_inc;
    logic [4*DIGITS-1:0] r_bcd;
    logic [NW-1:0]       r_ndig;
    logic                r_res_valid, r_res_err;
    logic                w_got_digit, w_unused;

    assign w_timer_inc = r_timer + 1'b1;
    assign w_got_digit = (r_state == WAIT) && div_done && div_valid;
    // Remainder never exceeds 9, so only the low nibble carries information.
    assign w_unused    = ^div_rem[WIDTH-1:4];

    always_comb begin
        w_digits_wr = r_digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == NW'(i)) w_digits_wr[4*i +: 4] = div_rem[3:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_ndig_nxt  = r_idx;
        unique case (r_state)
            IDLE:    if (req_valid) w_state_nxt = ISSUE;
            ISSUE:   if (!div_busy) w_state_nxt = WAIT;
            WAIT: begin
                if (div_done) begin
                    w_state_nxt = PUBLISH;
                    if (!div_valid) begin
                        w_err_nxt = 1'b1;
                    end else if (div_val == '0) begin
                        w_ndig_nxt = r_idx + 1'b1;
                    end else if (r_idx == NW'(DIGITS-1)) begin
                        w_err_nxt  = 1'b1;
                        w_ndig_nxt = NW'(DIGITS);
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end else if (w_timer_inc == TW'(TIMEOUT-1)) begin
                    w_state_nxt = PUBLISH;
                    w_err_nxt   = 1'b1;
                end
            end
            PUBLISH: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_digits    <= '0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_timer     <= '0;
            r_bcd       <= '0;
            r_ndig      <= '0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_res_valid <= (w_state_nxt == PUBLISH);
            if (r_state == IDLE && req_valid) begin
                r_work   <= req_value;
                r_digits <= '0;
                r_idx    <= '0;
                r_err    <= 1'b0;
            end
            if (r_state == ISSUE && !div_busy) r_timer <= '0;
            if (r_state == WAIT) begin
                r_timer <= w_timer_inc;
                r_err   <= w_err_nxt;
                if (w_got_digit) begin
                    r_digits <= w_digits_wr;
                    r_work   <= div_val;
                    if (w_state_nxt == ISSUE) r_idx <= r_idx + 1'b1;
                end
                // Result registers load on the way into PUBLISH so they are valid with res_valid.
                if (w_state_nxt == PUBLISH) begin
                    r_bcd     <= w_got_digit ? w_digits_wr : r_digits;
                    r_ndig    <= w_ndig_nxt;
                    r_res_err <= w_err_nxt;
                end
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign div_start = (r_state == ISSUE) && !div_busy;
    assign div_a     = r_work;
    assign div_b     = WIDTH'(10);
    assign bcd_o     = r_bcd;
    assign ndigits_o = r_ndig;
    assign res_valid = r_res_valid;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: a 10-digit and a 4-digit instance share one divider model style.
module tb_bcd_conv_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] bcd;
        int          nd;
        logic        err;
        int          ns;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nchk = 0, nfail = 0, cyc = 0;
    int   ns0 = 0, ns1 = 0, t_start0 = 0, lat0 = 0;

    int   lat = 3;
    logic hang = 1'b0, derr = 1'b0, force_busy = 1'b0;

    // instance 0: default build
    logic        req_valid0, req_ready0, div_start0, div_busy0, res_valid0, res_err0, busy0;
    logic [31:0] req_value0, div_a0, div_b0;
    logic [39:0] bcd0;
    logic [3:0]  ndig0;
    // instance 1: DIGITS=4 build
    logic        req_valid1, req_ready1, div_start1, div_busy1, res_valid1, res_err1, busy1;
    logic [31:0] req_value1, div_a1, div_b1;
    logic [15:0] bcd1;
    logic [2:0]  ndig1;

    logic [1:0]  m_done, m_valid, m_pend;
    logic [31:0] m_val[2], m_rem[2], m_a[2];
    int          m_cnt[2];
    logic [1:0]  m_start;
    logic [31:0] m_ain[2];

    assign m_start  = {div_start1, div_start0};
    assign m_ain[0] = div_a0;
    assign m_ain[1] = div_a1;
    assign div_busy0 = m_pend[0] | force_busy;
    assign div_busy1 = m_pend[1];

    bcd_conv_sched #(.WIDTH(32), .DIGITS(10), .TIMEOUT(64)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_value(req_value0), .req_ready(req_ready0),
        .div_start(div_start0), .div_a(div_a0), .div_b(div_b0), .div_busy(div_busy0),
        .div_done(m_done[0]), .div_valid(m_valid[0]), .div_val(m_val[0]), .div_rem(m_rem[0]),
        .bcd_o(bcd0), .ndigits_o(ndig0), .res_valid(res_valid0), .res_err(res_err0), .busy(busy0));

    bcd_conv_sched #(.WIDTH(32), .DIGITS(4), .TIMEOUT(64)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_value(req_value1), .req_ready(req_ready1),
        .div_start(div_start1), .div_a(div_a1), .div_b(div_b1), .div_busy(div_busy1),
        .div_done(m_done[1]), .div_valid(m_valid[1]), .div_val(m_val[1]), .div_rem(m_rem[1]),
        .bcd_o(bcd1), .ndigits_o(ndig1), .res_valid(res_valid1), .res_err(res_err1), .busy(busy1));

    // Iterative divider model: busy for lat cycles after start, then a one-cycle done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done  <= '0;
            m_valid <= '0;
            m_pend  <= '0;
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] <= 0; m_val[k] <= '0; m_rem[k] <= '0; m_a[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= 1'b0;
                if (m_start[k]) begin
                    m_pend[k] <= 1'b1;
                    m_cnt[k]  <= lat - 1;
                    m_a[k]    <= m_ain[k];
                end else if (m_pend[k]) begin
                    if (m_cnt[k] == 0) begin
                        m_pend[k] <= 1'b0;
                        if (!hang) begin
                            m_done[k]  <= 1'b1;
                            m_valid[k] <= ~derr;
                            m_val[k]   <= m_a[k] / 10;
                            m_rem[k]   <= m_a[k] % 10;
                        end
                    end else begin
                        m_cnt[k] <= m_cnt[k] - 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [39:0] b, input int nd, input logic er, input int ns);
        exp_t e;
        e.bcd = b; e.nd = nd; e.err = er; e.ns = ns;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ns0 = 0;
        end else begin
            if (div_start0) begin ns0++; t_start0 = cyc; end
            if (res_valid0) begin
                lat0 = cyc - t_start0;
                if (q0.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL unexpected_result0: got bcd %0h expected none", bcd0);
                end else begin
                    e = q0.pop_front();
                    chk("bcd0", 40'(bcd0), e.bcd);
                    chk("ndigits0", 40'(ndig0), 40'(e.nd));
                    chk("res_err0", 40'(res_err0), 40'(e.err));
                    chk("starts0", 40'(ns0), 40'(e.ns));
                end
                ns0 = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ns1 = 0;
        end else begin
            if (div_start1) ns1++;
            if (res_valid1) begin
                if (q1.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL unexpected_result1: got bcd %0h expected none", bcd1);
                end else begin
                    e = q1.pop_front();
                    chk("bcd1", 40'(bcd1), e.bcd);
                    chk("ndigits1", 40'(ndig1), 40'(e.nd));
                    chk("res_err1", 40'(res_err1), 40'(e.err));
                    chk("starts1", 40'(ns1), 40'(e.ns));
                end
                ns1 = 0;
            end
        end
    end

    task automatic send0(input logic [31:0] v);
        int n = 0;
        while (!req_ready0 && n < 200) begin @(posedge clk); #1; n++; end
        if (!req_ready0) begin nchk++; nfail++; $display("FAIL ready0_timeout: got 0 expected 1"); end
        req_valid0 = 1'b1; req_value0 = v;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] v);
        int n = 0;
        while (!req_ready1 && n < 200) begin @(posedge clk); #1; n++; end
        if (!req_ready1) begin nchk++; nfail++; $display("FAIL ready1_timeout: got 0 expected 1"); end
        req_valid1 = 1'b1; req_value1 = v;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin @(posedge clk); n++; end
        if (q0.size() != 0 || q1.size() != 0) begin
            nchk++; nfail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size());
            q0.delete(); q1.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid0 = 1'b0; req_value0 = '0;
        req_valid1 = 1'b0; req_value1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", 40'(res_valid0), 40'(0));
        chk("rst_div_start", 40'(div_start0), 40'(0));
        chk("rst_bcd", 40'(bcd0), 40'(0));
        chk("rst_ndigits", 40'(ndig0), 40'(0));
        chk("rst_res_err", 40'(res_err0), 40'(0));
        chk("rst_busy", 40'(busy0), 40'(0));
        chk("div_b_const", 40'(div_b0), 40'(10));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 40'(req_ready0), 40'(1));

        q0.push_back(mk(40'h1234, 4, 1'b0, 4));          send0(32'd1234);     drain();
        q0.push_back(mk(40'h0, 1, 1'b0, 1));             send0(32'd0);        drain();
        q0.push_back(mk(40'h4294967295, 10, 1'b0, 10));  send0(32'hFFFFFFFF); drain();
        q1.push_back(mk(40'h2345, 4, 1'b1, 4));          send1(32'd12345);    drain();

        hang = 1'b1;
        q0.push_back(mk(40'h0, 0, 1'b1, 1));             send0(32'd77);       drain();
        chk("timeout_latency", 40'(lat0), 40'(64));
        hang = 1'b0;

        derr = 1'b1;
        q0.push_back(mk(40'h0, 0, 1'b1, 1));             send0(32'd98);       drain();
        derr = 1'b0;

        force_busy = 1'b1;
        q0.push_back(mk(40'h7, 1, 1'b0, 1));             send0(32'd7);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_no_start", 40'(ns0), 40'(0));
        chk("stall_busy", 40'(busy0), 40'(1));
        force_busy = 1'b0;
        #1;
        chk("start_on_release", 40'(div_start0), 40'(1));
        drain();

        send0(32'd98765);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_conv_busy", 40'(busy0), 40'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_start", 40'(div_start0), 40'(0));
        chk("post_rst_busy", 40'(busy0), 40'(0));
        q0.push_back(mk(40'h56, 2, 1'b0, 2));            send0(32'd56);       drain();
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
